seq_alu_exec: RTL and testbench

- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Takes an operation code plus operands through a valid/ready handshake, executes it, and returns the result and flags through a second valid/ready handshake.
- Logical and arithmetic ops take one cycle. SLL/SRL are iterative, one bit per cycle, so the datapath can run multicycle without a barrel shifter.
- Sits between the decode/operand-fetch stage and writeback.

---
 rtl/seq_alu_exec_pkg.sv | 24 ++
 rtl/seq_alu_exec_if.sv | 27 ++
 rtl/seq_alu_exec_shifter.sv | 53 +++++
 rtl/seq_alu_exec.sv | 137 +++++++++++++
 tb/tb_seq_alu_exec.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_exec_pkg.sv
// Shared op codes and FSM encoding for the sequential ALU execute stage.
// The ALU control decoder uses the same op code constants.
package seq_alu_exec_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/seq_alu_exec_if.sv
// Request/response handshake bundle between operand fetch, the ALU and writeback.
interface seq_alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_operation;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   alu_result;
    logic               zero;
    logic               illegal_op;

    modport master (
        output in_valid, alu_operation, op_a, op_b, shamt, out_ready,
        input  in_ready, out_valid, alu_result, zero, illegal_op
    );

    modport slave (
        input  in_valid, alu_operation, op_a, op_b, shamt, out_ready,
        output in_ready, out_valid, alu_result, zero, illegal_op
    );
endinterface

// File: rtl/seq_alu_exec_shifter.sv
// seq_alu_shifter: one-bit-per-cycle shift register with down counter, or a
// combinational barrel shifter when SEQ_ALU_BARREL_EN is defined.
module seq_alu_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
`ifndef SEQ_ALU_BARREL_EN
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    output logic               last_o,
`endif
    input  logic               left_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   data_o
);

`ifdef SEQ_ALU_BARREL_EN
    assign data_o = left_i ? (data_i << shamt_i) : (data_i >> shamt_i);
`else
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic [WIDTH-1:0]   shift1_s;

    assign shift1_s = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    // data_o is the value after the step taken this cycle; valid to capture when last_o is high
    assign data_o   = shift1_s;
    assign last_o   = (cnt_q == SHAMT_W'(1));

    // Working register, direction and remaining-step counter
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else if (load_i) begin
            work_q <= data_i;
            cnt_q  <= shamt_i;
            left_q <= left_i;
        end else if (step_i && (cnt_q != '0)) begin
            work_q <= shift1_s;
            cnt_q  <= cnt_q - SHAMT_W'(1);
        end else begin
            work_q <= work_q;
            cnt_q  <= cnt_q;
        end
    end
`endif

endmodule

// File: rtl/seq_alu_exec.sv
// Sequential ALU execute stage: valid/ready in, valid/ready out, iterative shifts.
// Define SEQ_ALU_BARREL_EN to make SLL/SRL single-cycle through a barrel shifter.
module seq_alu_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic           clk,
    input logic           reset,
    seq_alu_exec_if.slave bus
);
    import seq_alu_exec_pkg::*;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_val_s;
    logic             alu_ill_s;
    logic [WIDTH-1:0] shift_data_s;
    logic             go_shift_s;

`ifdef SEQ_ALU_BARREL_EN
    assign go_shift_s = 1'b0;

    seq_alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .left_i  (bus.alu_operation == OP_SLL),
        .data_i  (bus.op_b),
        .shamt_i (bus.shamt),
        .data_o  (shift_data_s)
    );
`else
    logic shift_last_s;

    // A zero shift amount completes like any single-cycle op
    assign go_shift_s = is_shift_op(bus.alu_operation) && (bus.shamt != '0);

    seq_alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_i  ((state_q == ST_IDLE) && bus.in_valid && go_shift_s),
        .step_i  (state_q == ST_SHIFT),
        .last_o  (shift_last_s),
        .left_i  (bus.alu_operation == OP_SLL),
        .data_i  (bus.op_b),
        .shamt_i (bus.shamt),
        .data_o  (shift_data_s)
    );
`endif

    // Single-cycle result for the op presented at the input
    always_comb begin
        alu_val_s = '0;
        alu_ill_s = 1'b0;
        case (bus.alu_operation)
            OP_AND:  alu_val_s = bus.op_a & bus.op_b;
            OP_OR:   alu_val_s = bus.op_a | bus.op_b;
            OP_NOR:  alu_val_s = ~(bus.op_a | bus.op_b);
            OP_ADD:  alu_val_s = bus.op_a + bus.op_b;
            OP_SUB:  alu_val_s = bus.op_a - bus.op_b;
`ifdef SEQ_ALU_BARREL_EN
            OP_SLL, OP_SRL: alu_val_s = shift_data_s;
`else
            OP_SLL, OP_SRL: alu_val_s = bus.op_b;
`endif
            default: begin
                alu_val_s = '0;
                alu_ill_s = 1'b1;
            end
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && go_shift_s) begin
                    state_d = ST_SHIFT;
                end else if (bus.in_valid) begin
                    result_d  = alu_val_s;
                    zero_d    = (alu_val_s == '0);
                    illegal_d = alu_ill_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef SEQ_ALU_BARREL_EN
                state_d = ST_IDLE;
`else
                if (shift_last_s) begin
                    result_d  = shift_data_s;
                    zero_d    = (shift_data_s == '0);
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
`endif
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_seq_alu_exec.sv
// Bench for seq_alu_exec: transaction-level model with per-cycle compare plus
// hand-computed directed vectors.
module tb_seq_alu_exec;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          due;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } lit_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_alu_exec_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    seq_alu_exec #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          started = 1'b0;
    logic [31:0] last_res = 32'h0;
    logic        last_z   = 1'b0;
    logic        last_ill = 1'b0;
    exp_t        pend[$];
    lit_t        lit_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outcome of one request, straight from the op table
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh, input int now);
        exp_t e;
        int   lat;
        e.res = 32'h0;
        e.ill = 1'b0;
        lat   = 1;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: e.res = ~(a | b);
            4'd3: e.res = a + b;
            4'd4: e.res = a - b;
            4'd5: begin e.res = b << sh; lat = int'(sh) + 1; end
            4'd6: begin e.res = b >> sh; lat = int'(sh) + 1; end
            default: e.ill = 1'b1;
        endcase
`ifdef SEQ_ALU_BARREL_EN
        lat = 1;
`endif
        e.z   = (e.res == 32'h0);
        e.due = now + lat;
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", n, act, req);
        end
    endtask

    task automatic lit(input string n, input logic [31:0] act, input logic [31:0] req);
        lit_t l;
        l.name = n;
        l.act  = act;
        l.req  = req;
        lit_q.push_back(l);
    endtask

    // The single compare process: literal results plus per-cycle model compare
    always @(negedge clk) begin : cmp
        bit   vis;
        lit_t l;
        vis = (pend.size() > 0) && (cyc >= pend[0].due);
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            chk(l.name, l.act, l.req);
        end
        if (started) begin
            if (vis) begin
                last_res = pend[0].res;
                last_z   = pend[0].z;
                last_ill = pend[0].ill;
            end
            chk("in_ready",   32'(bus.in_ready),   32'(pend.size() == 0));
            chk("out_valid",  32'(bus.out_valid),  32'(vis));
            chk("alu_result", bus.alu_result,      last_res);
            chk("zero",       32'(bus.zero),       32'(last_z));
            chk("illegal_op", 32'(bus.illegal_op), 32'(last_ill));
        end
        if (reset) begin
            pend.delete();
            last_res = 32'h0;
            last_z   = 1'b0;
            last_ill = 1'b0;
            started  = 1'b1;
        end else if (started) begin
            if ((pend.size() == 0) && bus.in_valid) begin
                pend.push_back(model(bus.alu_operation, bus.op_a, bus.op_b, bus.shamt, cyc));
            end else if (vis && bus.out_ready) begin
                void'(pend.pop_front());
            end
        end
    end

    // Offer a request at posedge+1; returns after the accepting edge (+1)
    task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input string tag, output bit acc);
        acc = 1'b0;
        bus.alu_operation = op;
        bus.op_a          = a;
        bus.op_b          = b;
        bus.shamt         = sh;
        bus.in_valid      = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) lit({tag, "_accept_timeout"}, 32'h0, 32'h1);
        bus.in_valid      = 1'b0;
        bus.alu_operation = 4'd3;
        bus.op_a          = 32'hDEADBEEF;
        bus.op_b          = 32'h5A5A5A5A;
        bus.shamt         = 5'd3;
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input int hold, input logic [31:0] exp_res,
                       input int exp_lat, input logic exp_z, input logic exp_ill, input string tag);
        bit acc;
        bit seen;
        int lat;
        @(posedge clk);
        #1;
        bus.out_ready = (hold == 0);
        offer(op, a, b, sh, tag, acc);
        if (acc) begin
            lat  = 0;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                lat++;
                if (bus.out_valid) seen = 1'b1;
            end
            if (!seen) begin
                lit({tag, "_valid_timeout"}, 32'h0, 32'h1);
            end else begin
                lit({tag, "_latency"},  32'(lat),            32'(exp_lat));
                lit({tag, "_result"},   bus.alu_result,      exp_res);
                lit({tag, "_zero"},     32'(bus.zero),       32'(exp_z));
                lit({tag, "_illegal"},  32'(bus.illegal_op), 32'(exp_ill));
                lit({tag, "_busy"},     32'(bus.in_ready),   32'h0);
                if (hold > 0) begin
                    repeat (hold) @(posedge clk);
                    #1;
                    bus.out_ready = 1'b1;
                    @(negedge clk);
                    lit({tag, "_held_valid"},  32'(bus.out_valid), 32'h1);
                    lit({tag, "_held_result"}, bus.alu_result,     exp_res);
                    lit({tag, "_held_busy"},   32'(bus.in_ready),  32'h0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                lit({tag, "_ready_after"}, 32'(bus.in_ready),  32'h1);
                lit({tag, "_valid_after"}, 32'(bus.out_valid), 32'h0);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit acc;
        int slat;
        int ilat;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b0;
        bus.alu_operation = 4'd0;
        bus.op_a          = 32'h0;
        bus.op_b          = 32'h0;
        bus.shamt         = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        lit("reset_in_ready",  32'(bus.in_ready),   32'h1);
        lit("reset_out_valid", 32'(bus.out_valid),  32'h0);
        lit("reset_result",    bus.alu_result,      32'h0);
        lit("reset_zero",      32'(bus.zero),       32'h0);
        lit("reset_illegal",   32'(bus.illegal_op), 32'h0);

`ifdef SEQ_ALU_BARREL_EN
        slat = 1;
        ilat = 1;
`else
        slat = 5;
        ilat = 32;
`endif
        run(4'd3, 32'hFFFFFFFF, 32'h00000001, 5'd0,  0, 32'h00000000, 1,    1'b1, 1'b0, "add_wrap");
        run(4'd4, 32'h00000005, 32'h00000007, 5'd0,  0, 32'hFFFFFFFE, 1,    1'b0, 1'b0, "sub_neg");
        run(4'd2, 32'h00000000, 32'h00000000, 5'd0,  0, 32'hFFFFFFFF, 1,    1'b0, 1'b0, "nor_zero");
        run(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  0, 32'h00F000F0, 1,    1'b0, 1'b0, "and");
        run(4'd1, 32'h12340000, 32'h00005678, 5'd0,  0, 32'h12345678, 1,    1'b0, 1'b0, "or");
        run(4'd5, 32'h00000000, 32'h00000001, 5'd4,  0, 32'h00000010, slat, 1'b0, 1'b0, "sll4");
        run(4'd6, 32'h00000000, 32'h80000000, 5'd31, 0, 32'h00000001, ilat, 1'b0, 1'b0, "srl31");
        run(4'd6, 32'h00000000, 32'h00001234, 5'd0,  0, 32'h00001234, 1,    1'b0, 1'b0, "srl0");
        run(4'd3, 32'h00000002, 32'h00000003, 5'd0,  4, 32'h00000005, 1,    1'b0, 1'b0, "add_bp");
        run(4'd9, 32'h00000005, 32'h00000005, 5'd0,  0, 32'h00000000, 1,    1'b1, 1'b1, "ill_1001");
        run(4'd15, 32'h00000001, 32'h00000001, 5'd2, 0, 32'h00000000, 1,    1'b1, 1'b1, "ill_1111");
`ifdef SEQ_ALU_BARREL_EN
        run(4'd5, 32'h00000000, 32'h80000001, 5'd1,  0, 32'h00000002, 1,    1'b0, 1'b0, "sll_msb");
`else
        run(4'd5, 32'h00000000, 32'h80000001, 5'd1,  0, 32'h00000002, 2,    1'b0, 1'b0, "sll_msb");
`endif

        // Abort a long shift with reset in its second cycle
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        offer(4'd5, 32'h0, 32'h00000001, 5'd10, "sll_abort", acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        lit("abort_in_ready",  32'(bus.in_ready),   32'h1);
        lit("abort_out_valid", 32'(bus.out_valid),  32'h0);
        lit("abort_result",    bus.alu_result,      32'h0);
        lit("abort_zero",      32'(bus.zero),       32'h0);
        lit("abort_illegal",   32'(bus.illegal_op), 32'h0);

        run(4'd0, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  1, 32'h0F0F0000, 1,    1'b0, 1'b0, "and_after");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
